// File: rtl/pe_pkg.sv
// Shared types and range helpers for the pipelined MAC processing element.
// Range math is done in a fixed wide signed domain so one helper serves any ACC_W.
package pe_pkg;

    localparam int PE_MAX_W = 128;

    typedef logic signed [PE_MAX_W-1:0] pe_wide_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } pe_flags_t;

    localparam pe_wide_t PE_ONE = pe_wide_t'(1);

    function automatic pe_wide_t pe_sat_max(input int acc_w, input logic is_signed);
        return is_signed ? (PE_ONE <<< (acc_w - 1)) - PE_ONE
                         : (PE_ONE <<< acc_w) - PE_ONE;
    endfunction

    function automatic pe_wide_t pe_sat_min(input int acc_w, input logic is_signed);
        return is_signed ? -(PE_ONE <<< (acc_w - 1)) : '0;
    endfunction

    function automatic logic pe_out_of_range(input pe_wide_t v, input int acc_w,
                                             input logic is_signed);
        return (v > pe_sat_max(acc_w, is_signed)) || (v < pe_sat_min(acc_w, is_signed));
    endfunction

endpackage

// File: rtl/pe_mult_stage.sv
// Operand/flag register stage (S1) followed by the full-width product register (S2).
// S1 outputs double as the systolic forwarding ports.
module pe_mult_stage
    import pe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [DATA_W-1:0]     a_out,
    output logic [DATA_W-1:0]     b_out,
    output logic                  fwd_valid,
    output pe_flags_t             s2_flags,
    output logic [2*DATA_W-1:0]   s2_prod
);

    localparam int PW = 2 * DATA_W;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    pe_flags_t         r_s1_flags;
    pe_flags_t         r_s2_flags;
    logic [PW-1:0]     r_s2_prod;
    logic [PW-1:0]     w_a_ext;
    logic [PW-1:0]     w_b_ext;
    logic [PW-1:0]     w_prod;

    // Extending both operands to 2*DATA_W makes the low half of one multiply correct for either mode.
    generate
        if (SIGNED != 0) begin : g_sext
            assign w_a_ext = {{DATA_W{r_a[DATA_W-1]}}, r_a};
            assign w_b_ext = {{DATA_W{r_b[DATA_W-1]}}, r_b};
        end else begin : g_zext
            assign w_a_ext = {{DATA_W{1'b0}}, r_a};
            assign w_b_ext = {{DATA_W{1'b0}}, r_b};
        end
    endgenerate

    assign w_prod = w_a_ext * w_b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_s1_flags <= '0;
            r_s2_flags <= '0;
            r_s2_prod  <= '0;
        end else begin
            r_a        <= a;
            r_b        <= b;
            r_s1_flags <= '{valid: in_valid, first: in_first, last: in_last};
            r_s2_flags <= r_s1_flags;
            r_s2_prod  <= w_prod;
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign fwd_valid = r_s1_flags.valid;
    assign s2_flags  = r_s2_flags;
    assign s2_prod   = r_s2_prod;

endmodule

// File: rtl/pe_mac_pipe.sv
// Pipelined multiply-accumulate PE: multiplier stages plus the S3 accumulator with
// optional saturation, sticky per-frame overflow and a result-valid pulse.
module pe_mac_pipe
    import pe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ACC_W    = 32,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              fwd_valid,
    output logic [ACC_W-1:0]  c,
    output logic              out_valid,
    output logic              overflow
);

    localparam int   PW        = 2 * DATA_W;
    localparam logic IS_SIGNED = (SIGNED != 0);

    pe_flags_t        w_s2_flags;
    logic [PW-1:0]    w_s2_prod;
    pe_wide_t         w_prod_ext;
    pe_wide_t         w_acc_ext;
    pe_wide_t         w_base;
    pe_wide_t         w_sum;
    logic             w_prod_ovf;
    logic             w_sum_ovf;
    logic             w_ovf;
    logic             w_sat_high;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             r_out_valid;

    pe_mult_stage #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .a         (a),
        .b         (b),
        .a_out     (a_out),
        .b_out     (b_out),
        .fwd_valid (fwd_valid),
        .s2_flags  (w_s2_flags),
        .s2_prod   (w_s2_prod)
    );

    generate
        if (IS_SIGNED) begin : g_sext
            assign w_prod_ext = {{(PE_MAX_W-PW){w_s2_prod[PW-1]}}, w_s2_prod};
            assign w_acc_ext  = {{(PE_MAX_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
        end else begin : g_zext
            assign w_prod_ext = {{(PE_MAX_W-PW){1'b0}}, w_s2_prod};
            assign w_acc_ext  = {{(PE_MAX_W-ACC_W){1'b0}}, r_acc};
        end
    endgenerate

    // Exact wide sum; a product that alone exceeds ACC_W counts as overflow even if the sum lands in range.
    assign w_base     = w_s2_flags.first ? '0 : w_acc_ext;
    assign w_sum      = w_base + w_prod_ext;
    assign w_prod_ovf = pe_out_of_range(w_prod_ext, ACC_W, IS_SIGNED);
    assign w_sum_ovf  = pe_out_of_range(w_sum, ACC_W, IS_SIGNED);
    assign w_ovf      = w_prod_ovf | w_sum_ovf;
    assign w_sat_high = !IS_SIGNED ||
                        (w_prod_ovf ? !w_prod_ext[PE_MAX_W-1] : !w_sum[PE_MAX_W-1]);

    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        if ((SATURATE != 0) && w_ovf) begin
            w_acc_next = w_sat_high ? ACC_W'(pe_sat_max(ACC_W, IS_SIGNED))
                                    : ACC_W'(pe_sat_min(ACC_W, IS_SIGNED));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_s2_flags.valid & w_s2_flags.last;
            if (w_s2_flags.valid) begin
                r_acc <= w_acc_next;
                r_ovf <= w_s2_flags.first ? w_ovf : (r_ovf | w_ovf);
            end
        end
    end

    assign c         = r_acc;
    assign overflow  = r_ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Scoreboard bench for pe_mac_pipe: four configurations share one stimulus stream,
// a behavioural model queues expected results, and a monitor checks each out_valid pulse.
module tb_pe_mac_pipe;

    typedef struct {
        longint c;
        bit     ovf;
        int     cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_first, in_last;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;

    logic [31:0] a_out0, b_out0, c0;
    logic [7:0]  a_out1, b_out1, a_out2, b_out2, a_out3, b_out3;
    logic [15:0] c1;
    logic [7:0]  c2, c3;
    logic [3:0]  fwd, ov, ovf;

    int     n_chk  = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    int     n_pulse0 = 0;
    int     p0;

    int     dat_w [4] = '{32, 8, 8, 8};
    int     acc_w [4] = '{32, 16, 8, 8};
    bit     sgn   [4] = '{0, 1, 0, 0};
    bit     sat   [4] = '{0, 0, 1, 0};
    longint m_acc [4];
    bit     m_ovf [4];
    exp_t   sb [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_mac_pipe #(.DATA_W(32), .ACC_W(32), .SIGNED(0), .SATURATE(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .a(a32), .b(b32), .a_out(a_out0), .b_out(b_out0), .fwd_valid(fwd[0]),
        .c(c0), .out_valid(ov[0]), .overflow(ovf[0]));
    pe_mac_pipe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .a(a8), .b(b8), .a_out(a_out1), .b_out(b_out1), .fwd_valid(fwd[1]),
        .c(c1), .out_valid(ov[1]), .overflow(ovf[1]));
    pe_mac_pipe #(.DATA_W(8), .ACC_W(8), .SIGNED(0), .SATURATE(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .a(a8), .b(b8), .a_out(a_out2), .b_out(b_out2), .fwd_valid(fwd[2]),
        .c(c2), .out_valid(ov[2]), .overflow(ovf[2]));
    pe_mac_pipe #(.DATA_W(8), .ACC_W(8), .SIGNED(0), .SATURATE(0)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .a(a8), .b(b8), .a_out(a_out3), .b_out(b_out3), .fwd_valid(fwd[3]),
        .c(c3), .out_valid(ov[3]), .overflow(ovf[3]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint get_c(input int id);
        case (id)
            0:       return longint'(c0);
            1:       return longint'(c1);
            2:       return longint'(c2);
            default: return longint'(c3);
        endcase
    endfunction

    // Reference: interpret operands per mode, form the exact result, then clamp or wrap.
    function automatic void model_step(input int id, input longint av, input longint bv,
                                       input bit first);
        longint dm = (longint'(1) << dat_w[id]) - 1;
        longint am = (longint'(1) << acc_w[id]) - 1;
        longint x = av & dm;
        longint y = bv & dm;
        longint lo, hi, base, p, s, r;
        bit     o;
        base = first ? 0 : m_acc[id];
        if (sgn[id]) begin
            if ((x >> (dat_w[id] - 1)) != 0) x -= dm + 1;
            if ((y >> (dat_w[id] - 1)) != 0) y -= dm + 1;
            if (!first && ((base >> (acc_w[id] - 1)) != 0)) base -= am + 1;
            lo = -(longint'(1) << (acc_w[id] - 1));
            hi = -lo - 1;
        end else begin
            lo = 0;
            hi = am;
        end
        p = x * y;
        s = base + p;
        o = (p < lo) || (p > hi) || (s < lo) || (s > hi);
        r = (o && sat[id]) ? ((s < lo) ? lo : hi) : s;
        m_acc[id] = r & am;
        m_ovf[id] = first ? o : (m_ovf[id] | o);
    endfunction

    task automatic term(input longint av, input longint bv, input bit first, input bit last);
        exp_t e;
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        a32 = av[31:0];
        b32 = bv[31:0];
        a8  = av[7:0];
        b8  = bv[7:0];
        for (int id = 0; id < 4; id++) begin
            model_step(id, av, bv, first);
            if (last) begin
                e.c   = m_acc[id];
                e.ovf = m_ovf[id];
                e.cyc = cyc + 3;
                sb[id].push_back(e);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        for (int id = 0; id < 4; id++) begin
            m_acc[id] = 0;
            m_ovf[id] = 1'b0;
        end
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int id = 0; id < 4; id++) begin
            if (ov[id] === 1'b1) begin
                exp_t e;
                if (id == 0) n_pulse0++;
                if (sb[id].size() == 0) begin
                    chk($sformatf("spurious_out_valid_dut%0d", id), 64'd1, 64'd0);
                end else begin
                    e = sb[id].pop_front();
                    $display("txn dut%0d cyc=%0d c=%0h ovf=%0b exp_c=%0h exp_ovf=%0b",
                             id, cyc, get_c(id), ovf[id], e.c, e.ovf);
                    chk($sformatf("c_dut%0d", id), get_c(id), e.c);
                    chk($sformatf("ovf_dut%0d", id), {63'd0, ovf[id]}, {63'd0, e.ovf});
                    chk($sformatf("latency_dut%0d", id), cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        do_reset(2);

        chk("rst_c0", c0, 0);
        chk("rst_c1", c1, 0);
        chk("rst_a_out", a_out0, 0);
        chk("rst_b_out", b_out0, 0);
        chk("rst_fwd", fwd, 0);
        chk("rst_out_valid", ov, 0);
        chk("rst_overflow", ovf, 0);

        // Forwarding appears one edge after sampling; the accumulator has not moved yet.
        term(5, 7, 1, 0);
        chk("fwd_a", a_out0, 5);
        chk("fwd_b", b_out0, 7);
        chk("fwd_valid", fwd[0], 1);
        chk("fwd_c_unchanged", c0, 0);
        idle(4);

        term(1, 1, 1, 0); term(2, 2, 0, 0); term(3, 3, 0, 1);
        idle(5);
        chk("dot14_c", c0, 14);
        chk("dot14_ovf", ovf[0], 0);

        term(-3, 4, 1, 0); term(2, 5, 0, 1);
        idle(5);
        chk("signed_c", c1, 16'hFFFE);
        chk("signed_ovf", ovf[1], 0);

        term(16, 16, 1, 1);
        idle(5);
        chk("sat_c", c2, 8'hFF);
        chk("sat_ovf", ovf[2], 1);
        chk("wrap_c", c3, 8'h00);
        chk("wrap_ovf", ovf[3], 1);
        term(1, 1, 1, 1);
        idle(5);
        chk("clear_sat_c", c2, 1);
        chk("clear_sat_ovf", ovf[2], 0);
        chk("clear_wrap_ovf", ovf[3], 0);

        p0 = n_pulse0;
        term(1, 1, 1, 0); idle(2); term(2, 2, 0, 0); idle(1); term(3, 3, 0, 1);
        idle(5);
        chk("bubble_c", c0, 14);
        chk("bubble_pulses", n_pulse0 - p0, 1);

        p0 = n_pulse0;
        term(9, 9, 1, 0); term(4, 4, 0, 0);
        do_reset(1);
        term(2, 3, 0, 1);
        idle(5);
        chk("rst_mid_c", c0, 6);
        chk("rst_mid_pulses", n_pulse0 - p0, 1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                term(longint'($urandom_range(0, 255)) - 128, longint'($urandom_range(0, 127)),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            end
        end
        term(3, 3, 0, 1);
        idle(6);

        for (int id = 0; id < 4; id++) begin
            chk($sformatf("sb_empty_dut%0d", id), sb[id].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
